// File: rtl/store_demux_pkg.sv
// Shared types and constants for the store demux.
// Size codes, FSM states, error causes and the target write bundle.
package store_demux_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IO_WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tgt_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_steer.sv
// Byte-lane steering for sb/sh/sw stores.
// in: size, addr_lo, wdata; out: st_wdata, be, misaligned.
module store_lane_steer
  import store_demux_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  always_comb begin
    st_wdata   = wdata;
    be         = 4'b0000;
    misaligned = 1'b0;
    unique case (size)
      SZ_B: begin
        st_wdata = {4{wdata[7:0]}};
        be       = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        st_wdata   = {2{wdata[15:0]}};
        be         = addr_lo[1] ? 4'b1100
                                : 4'b0011;
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_demux.sv
// Routes one CPU store to data memory or MMIO with timeout.
// Ports: req_* in, stall out, mem/io valid-ready, tgt_* bus, err.
module store_demux
  import store_demux_pkg::*;
#(
  parameter int             n         = 32,
  parameter logic [n-1:0]   MMIO_BASE = 32'hFFFF_0000,
  parameter int             TIMEOUT   = 16
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  input  logic [1:0]   req_size,
  output logic         stall,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic         io_valid,
  input  logic         io_ready,
  output logic [n-1:0] tgt_addr,
  output logic [n-1:0] tgt_wdata,
  output logic [3:0]   tgt_be,
  output logic         err,
  output logic [1:0]   err_cause
);

  localparam int CW = (TIMEOUT > 2)
                    ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  tgt_t          tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mv_q, mv_d;
  logic          iv_q, iv_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;

  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic          misal;
  logic          rdy;

  store_lane_steer u_steer (
    .size       (req_size),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .st_wdata   (st_wdata),
    .be         (st_be),
    .misaligned (misal)
  );

  assign stall = (state_q != IDLE);

  // Only the selected target's ready matters.
  assign rdy = (state_q == MEM_WAIT)
             ? mem_ready : io_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      iv_q    <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      iv_q    <= iv_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    mv_d    = mv_q;
    iv_d    = iv_q;
    err_d   = 1'b0;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !stall) begin
          if (misal) begin
            err_d   = 1'b1;
            cause_d = ERR_MISALIGN;
          end else begin
            tgt_d.addr  = word_align(req_addr);
            tgt_d.wdata = st_wdata;
            tgt_d.be    = st_be;
            cnt_d       = '0;
            if (req_addr < MMIO_BASE) begin
              state_d = MEM_WAIT;
              mv_d    = 1'b1;
            end else begin
              state_d = IO_WAIT;
              iv_d    = 1'b1;
            end
          end
        end
      end
      MEM_WAIT, IO_WAIT: begin
        // Ready on the last counted cycle still completes.
        if (rdy) begin
          state_d = IDLE;
          mv_d    = 1'b0;
          iv_d    = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          mv_d    = 1'b0;
          iv_d    = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          cause_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        mv_d    = 1'b0;
        iv_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_valid = mv_q;
  assign io_valid  = iv_q;
  assign tgt_addr  = tgt_q.addr;
  assign tgt_wdata = tgt_q.wdata;
  assign tgt_be    = tgt_q.be;
  assign err       = err_q;
  assign err_cause = cause_q;

  a_one_target: assert property (
    @(posedge clk) disable iff (rst)
    !(mv_q && iv_q));

  a_hold_bus: assert property (
    @(posedge clk) disable iff (rst)
    (state_q != IDLE &&
     $past(state_q) == state_q)
    |-> $stable(tgt_q));

endmodule
